wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Schedules writebacks from NUM_LANES execution lanes onto the single register-file write port (8 x 16-bit regs).
- Sits between the lane pipelines and writeback_unit; drives its iswb/isld-resolved data as wb_en/wb_rd/wb_data.
- Per-lane FIFO buffering absorbs port conflicts.
- Arbitration is round-robin with a same-destination age rule, so writes to one register land in program order.

Parameters:
- NUM_LANES, 2, number of requesting lanes (2..4).
- DEPTH, 2, per-lane FIFO entries (power of two, >=2).
- SEQ_W, 4, width of program-order sequence tag.

Ports:
- clk  input  1  clock, all state rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous; discards all buffered requests.
- req_valid  input  NUM_LANES  per-lane request valid.
- req_ready  output  NUM_LANES  per-lane FIFO not full.
- req_isld  input  NUM_LANES  1 = use ldresult, 0 = use aluresult.
- req_rd  input  3*NUM_LANES  destination register, lane i at [3i+:3].
- req_ldresult  input  16*NUM_LANES  load result, lane i at [16i+:16].
- req_aluresult  input  16*NUM_LANES  ALU result, lane i at [16i+:16].
- req_seq  input  SEQ_W*NUM_LANES  program-order tag, lane i at [SEQ_W*i+:SEQ_W].
- wb_en  output  1  register-file write enable.
- wb_rd  output  3  write address.
- wb_data  output  16  write data.
- wb_lane  output  $clog2(NUM_LANES)  lane granted (debug/forwarding).

Behaviour:
- Reset (async, rst=1):
  - FIFOs empty; rr_ptr=0.
  - wb_en=0, wb_rd=0, wb_data=0, wb_lane=0.
  - req_ready=all ones once rst deasserts.
- Push:
  - Accepted on an edge where req_valid[i]&req_ready[i].
  - Entry stores {rd, seq, data}; data is muxed at push (isld ? ldresult : aluresult).
- req_ready[i] = !full[i]. It is combinational from count only, independent of the same-cycle pop; a full FIFO accepts nothing that cycle.
- Eligibility:
  - Lane i is eligible if its FIFO is non-empty and no other non-empty head has the same rd with an older seq.
  - a older than b iff (a-b) mod 2^SEQ_W has MSB set.
  - Equal seq on the same rd: lower lane index wins.
- Grant:
  - First eligible lane searching from rr_ptr upward with wrap.
  - On grant, pop that head; rr_ptr <= (grant+1) mod NUM_LANES.
  - No eligible lane: rr_ptr unchanged, no pop.
- Outputs registered:
  - Grant at edge E sets wb_en=1, wb_rd/wb_data/wb_lane from the popped head, for the cycle after E.
  - With no grant, wb_en=0 and wb_rd/wb_data hold their previous values.
- Latency: request accepted at edge E0 into an empty FIFO with no competitor -> granted at E1 -> wb_en high in the cycle after E1. Throughput is one write per cycle total.
- Simultaneous push and pop on the same FIFO: both happen, count unchanged.
- Pointers wrap modulo DEPTH.
- flush=1 at edge:
  - All FIFOs emptied; wb_en=0 next cycle.
  - Any same-edge push is dropped; rr_ptr reset to 0.
  - Flush beats push and grant.
- rst mid-operation: all buffered entries lost immediately; no wb_en pulse emitted.
- rd=0 is written like any other register; the register file decides policy.

Optional Feature:
- WBARB_PERF_EN: adds output perf_conflicts[15:0], a saturating counter.
  - Increments on each edge where at least one non-empty lane is not granted (conflict or age block).
  - Cleared by rst only, not by flush; holds at 16'hFFFF.
- Without the macro, the port and counter are absent.

Decomposition:
- Shared package wb_pkg:
  - REG_W=16, RD_W=3, NUM_REGS=8.
  - wb_entry_t typedef {rd, seq, data}.
  - function seq_older(a,b).
- One natural sub-module, wb_lane_fifo: a DEPTH-entry FIFO with push/pop/flush and full/empty/head outputs, instantiated NUM_LANES times.
- The arbiter and output register stay in the top module.

Test Plan:
- Single request: lane0 rd=1 isld=0 alu=ABCD seq=0 -> wb_en=1, wb_rd=1, wb_data=ABCD, wb_lane=0 one cycle after acceptance, then wb_en=0.
- Round-robin: lanes 0 and 1 every cycle, distinct rd (2,3), ld=1234/5678 -> grants alternate 0,1,0,1; each FIFO fills, req_ready drops to 0 when full.
- Age rule:
  - Lane1 rd=5 seq=3 and lane0 rd=5 seq=4 are both at head with rr_ptr=0 -> lane1 (data first) then lane0 written.
  - With seq=F on lane1 vs seq=0 on lane0, F is older across the wrap.
- Full boundary: hold lane0 valid for DEPTH+1 cycles while lane1 always wins (blocked by age) -> exactly DEPTH accepted, no overwrite, all later drained in order.
- Flush: 2 entries buffered per lane, flush=1 with a concurrent push -> wb_en=0 next cycle, both FIFOs empty, pushed entry never written.
- Async reset mid-stream: assert rst between edges -> wb_en/wb_rd/wb_data go to 0 immediately; with WBARB_PERF_EN the conflict count is restored to 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback arbiter (wb_arbiter, wb_lane_fifo).
// Sequence tags are stored zero-extended to SEQ_MAX_W bits; the tag MSB is selected with a mask.
package wb_pkg;

    localparam int REG_W     = 16;
    localparam int RD_W      = 3;
    localparam int NUM_REGS  = 8;
    localparam int SEQ_MAX_W = 8;

    typedef struct packed {
        logic [RD_W-1:0]      rd;
        logic [SEQ_MAX_W-1:0] seq;
        logic [REG_W-1:0]     data;
    } wb_entry_t;

    // a is older than b when (a - b) mod 2^SEQ_W has its MSB set; msb selects bit SEQ_W-1.
    function automatic logic seq_older(input logic [SEQ_MAX_W-1:0] a,
                                       input logic [SEQ_MAX_W-1:0] b,
                                       input logic [SEQ_MAX_W-1:0] msb);
        logic [SEQ_MAX_W-1:0] diff;
        diff = a - b;
        return |(diff & msb);
    endfunction

endpackage

// File: rtl/wb_lane_fifo.sv
// Per-lane writeback request FIFO: DEPTH entries (power of two), flush beats push and pop.
module wb_lane_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign empty     = (count_r == (PTR_W+1)'(0));
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full && !flush;
    assign do_pop_s  = pop && !empty && !flush;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_entry;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter with same-destination age ordering onto one register-file port.
// Optional WBARB_PERF_EN adds a saturating perf_conflicts counter output.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int  NUM_LANES = 2,
    parameter int  DEPTH     = 2,
    parameter int  SEQ_W     = 4,
    localparam int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_LANES-1:0]        req_valid,
    output logic [NUM_LANES-1:0]        req_ready,
    input  logic [NUM_LANES-1:0]        req_isld,
    input  logic [RD_W*NUM_LANES-1:0]   req_rd,
    input  logic [REG_W*NUM_LANES-1:0]  req_ldresult,
    input  logic [REG_W*NUM_LANES-1:0]  req_aluresult,
    input  logic [SEQ_W*NUM_LANES-1:0]  req_seq,
    output logic                        wb_en,
    output logic [RD_W-1:0]             wb_rd,
    output logic [REG_W-1:0]            wb_data,
    output logic [LANE_W-1:0]           wb_lane
`ifdef WBARB_PERF_EN
    ,
    output logic [15:0]                 perf_conflicts
`endif
);

    localparam logic [SEQ_MAX_W-1:0] SEQ_MSB = SEQ_MAX_W'(1) << (SEQ_W - 1);
    localparam logic [LANE_W:0]      LANES_L = (LANE_W+1)'(NUM_LANES);

    wb_entry_t             push_entry_s [NUM_LANES];
    wb_entry_t             head_s       [NUM_LANES];
    wb_entry_t             grant_head_s;
    logic [NUM_LANES-1:0]  full_s;
    logic [NUM_LANES-1:0]  empty_s;
    logic [NUM_LANES-1:0]  push_s;
    logic [NUM_LANES-1:0]  pop_s;
    logic [NUM_LANES-1:0]  blocked_s;
    logic [NUM_LANES-1:0]  elig_s;
    logic [NUM_LANES-1:0]  rot_s;
    logic                  grant_valid_s;
    logic [LANE_W:0]       grant_off_s;
    logic [LANE_W:0]       grant_sum_s;
    logic [LANE_W:0]       grant_inc_s;
    logic [LANE_W-1:0]     grant_idx_s;
    logic [LANE_W-1:0]     next_rr_s;
    logic [LANE_W-1:0]     rr_ptr_r;

    assign req_ready = ~full_s;
    assign push_s    = req_valid & ~full_s;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign push_entry_s[g] = '{
            rd:   req_rd[RD_W*g +: RD_W],
            seq:  SEQ_MAX_W'(req_seq[SEQ_W*g +: SEQ_W]),
            data: req_isld[g] ? req_ldresult[REG_W*g +: REG_W] : req_aluresult[REG_W*g +: REG_W]
        };

        wb_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .push       (push_s[g]),
            .push_entry (push_entry_s[g]),
            .pop        (pop_s[g]),
            .full       (full_s[g]),
            .empty      (empty_s[g]),
            .head       (head_s[g])
        );
    end

    // A head is blocked by any other head to the same rd that is older, or equal-aged on a lower lane.
    always_comb begin
        blocked_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = 0; j < NUM_LANES; j++) begin
                blocked_s[i] = blocked_s[i] |
                    ((i != j) && !empty_s[j] && (head_s[j].rd == head_s[i].rd) &&
                     (seq_older(head_s[j].seq, head_s[i].seq, SEQ_MSB) ||
                      ((head_s[j].seq == head_s[i].seq) && (j < i))));
            end
        end
        elig_s = ~empty_s & ~blocked_s;
    end

    // Rotate eligibility so bit 0 is rr_ptr, pick the lowest set bit, then rotate back.
    always_comb begin
        rot_s         = NUM_LANES'({elig_s, elig_s} >> rr_ptr_r);
        grant_valid_s = |rot_s;
        grant_off_s   = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (rot_s[k]) grant_off_s = (LANE_W+1)'(k);
            else          grant_off_s = grant_off_s;
        end
        grant_sum_s = {1'b0, rr_ptr_r} + grant_off_s;
        grant_idx_s = (grant_sum_s >= LANES_L) ? LANE_W'(grant_sum_s - LANES_L) : LANE_W'(grant_sum_s);
        grant_inc_s = {1'b0, grant_idx_s} + (LANE_W+1)'(1);
        next_rr_s   = (grant_inc_s >= LANES_L) ? '0 : LANE_W'(grant_inc_s);
    end

    // Granted head selection and pop vector.
    always_comb begin
        grant_head_s = head_s[0];
        for (int l = 0; l < NUM_LANES; l++) begin
            if (grant_idx_s == LANE_W'(l)) grant_head_s = head_s[l];
            else                           grant_head_s = grant_head_s;
        end
        if (grant_valid_s && !flush) pop_s = NUM_LANES'(1) << grant_idx_s;
        else                         pop_s = '0;
    end

    // Registered write port and round-robin pointer; wb_rd/wb_data/wb_lane hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_lane  <= '0;
            rr_ptr_r <= '0;
        end else if (flush) begin
            wb_en    <= 1'b0;
            rr_ptr_r <= '0;
        end else if (grant_valid_s) begin
            wb_en    <= 1'b1;
            wb_rd    <= grant_head_s.rd;
            wb_data  <= grant_head_s.data;
            wb_lane  <= grant_idx_s;
            rr_ptr_r <= next_rr_s;
        end else begin
            wb_en    <= 1'b0;
        end
    end

`ifdef WBARB_PERF_EN
    // Counts edges where some buffered lane is left waiting; saturates, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflicts <= 16'h0000;
        end else if ((|(~empty_s & ~pop_s)) && (perf_conflicts != 16'hFFFF)) begin
            perf_conflicts <= perf_conflicts + 16'h0001;
        end else begin
            perf_conflicts <= perf_conflicts;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts each edge's write.
module tb_wb_arbiter;

    localparam int NL    = 2;
    localparam int DEPTH = 2;
    localparam int SEQ_W = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic [NL-1:0]       req_valid = '0;
    logic [NL-1:0]       req_ready;
    logic [NL-1:0]       req_isld = '0;
    logic [3*NL-1:0]     req_rd = '0;
    logic [16*NL-1:0]    req_ldresult = '0;
    logic [16*NL-1:0]    req_aluresult = '0;
    logic [SEQ_W*NL-1:0] req_seq = '0;
    logic                wb_en;
    logic [2:0]          wb_rd;
    logic [15:0]         wb_data;
    logic                wb_lane;

    wb_arbiter #(.NUM_LANES(NL), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_isld(req_isld),
        .req_rd(req_rd), .req_ldresult(req_ldresult), .req_aluresult(req_aluresult),
        .req_seq(req_seq), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_lane(wb_lane)
    );

    always #5 clk = ~clk;

    typedef struct { int rd; int seq; int data; } ment_t;
    typedef struct { int edge_n; bit en; int rd; int data; int lane; int ready; } ev_t;

    ment_t mq [NL][$];
    ev_t   exp_q[$];
    int    m_rr = 0, m_rd = 0, m_data = 0;
    int    edge_cnt = 0;
    int    errors = 0, checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit older(input int a, input int b);
        return ((a - b) & ((1 << SEQ_W) - 1)) >= (1 << (SEQ_W - 1));
    endfunction

    // Reference model: decides what the next edge does from the queues and the current inputs.
    task automatic model_step();
        ev_t   ev;
        ment_t e;
        bit    elig [NL];
        int    sz [NL];
        int    g;
        ev.edge_n = edge_cnt + 1;
        ev.en = 1'b0;
        ev.lane = 0;
        g = -1;
        if (flush) begin
            for (int l = 0; l < NL; l++) mq[l].delete();
            m_rr = 0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                sz[i] = mq[i].size();
                elig[i] = (sz[i] > 0);
            end
            for (int i = 0; i < NL; i++)
                for (int j = 0; j < NL; j++)
                    if (j != i && sz[i] > 0 && sz[j] > 0 && mq[j][0].rd == mq[i][0].rd &&
                        (older(mq[j][0].seq, mq[i][0].seq) || (mq[j][0].seq == mq[i][0].seq && j < i)))
                        elig[i] = 1'b0;
            for (int k = 0; k < NL; k++)
                if (g < 0 && elig[(m_rr + k) % NL]) g = (m_rr + k) % NL;
            if (g >= 0) begin
                e = mq[g].pop_front();
                ev.en = 1'b1;
                ev.lane = g;
                m_rd = e.rd;
                m_data = e.data;
                m_rr = (g + 1) % NL;
            end
            for (int i = 0; i < NL; i++)
                if (req_valid[i] && sz[i] < DEPTH) begin
                    e.rd   = int'(req_rd[3*i +: 3]);
                    e.seq  = int'(req_seq[SEQ_W*i +: SEQ_W]);
                    e.data = req_isld[i] ? int'(req_ldresult[16*i +: 16]) : int'(req_aluresult[16*i +: 16]);
                    mq[i].push_back(e);
                end
        end
        ev.rd = m_rd;
        ev.data = m_data;
        ev.ready = 0;
        for (int i = 0; i < NL; i++) if (mq[i].size() < DEPTH) ev.ready |= (1 << i);
        exp_q.push_back(ev);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input bit v, input bit isld, input int rd,
                            input int ld, input int alu, input int sq);
        req_valid[i] = v;
        req_isld[i] = isld;
        req_rd[3*i +: 3] = 3'(rd);
        req_ldresult[16*i +: 16] = 16'(ld);
        req_aluresult[16*i +: 16] = 16'(alu);
        req_seq[SEQ_W*i +: SEQ_W] = SEQ_W'(sq);
    endtask

    task automatic clear();
        req_valid = '0;
        flush = 1'b0;
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: compares DUT outputs after each edge against that edge's predicted event.
    always @(negedge clk) begin
        ev_t ev;
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
                ev = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL stale_event: edge %0d never compared (now %0d)", ev.edge_n, edge_cnt);
            end
            if (exp_q.size() > 0 && exp_q[0].edge_n == edge_cnt) begin
                ev = exp_q.pop_front();
                chk("wb_en", int'(wb_en), int'(ev.en));
                chk("wb_rd", int'(wb_rd), ev.rd);
                chk("wb_data", int'(wb_data), ev.data);
                if (ev.en) chk("wb_lane", int'(wb_lane), ev.lane);
                chk("req_ready", int'(req_ready), ev.ready);
            end
        end
    end

    initial begin
        #2;
        chk("reset_wb_en", int'(wb_en), 0);
        chk("reset_wb_rd", int'(wb_rd), 0);
        chk("reset_wb_data", int'(wb_data), 0);
        chk("reset_wb_lane", int'(wb_lane), 0);
        #10 rst = 1'b0;
        #1 chk("reset_ready", int'(req_ready), 3);
        @(posedge clk);
        #1;

        set_lane(0, 1'b1, 1'b0, 1, 0, 'hABCD, 0);
        step();
        clear();
        step();
        chk("single_en", int'(wb_en), 1);
        chk("single_rd", int'(wb_rd), 1);
        chk("single_data", int'(wb_data), 'hABCD);
        chk("single_lane", int'(wb_lane), 0);
        step();
        chk("single_idle", int'(wb_en), 0);

        flush = 1'b1;
        step();
        clear();
        set_lane(0, 1'b1, 1'b0, 5, 0, 'h4444, 4);
        set_lane(1, 1'b1, 1'b0, 5, 0, 'h3333, 3);
        step();
        clear();
        step();
        chk("age_first_lane", int'(wb_lane), 1);
        chk("age_first_data", int'(wb_data), 'h3333);
        step();
        chk("age_second_lane", int'(wb_lane), 0);
        chk("age_second_data", int'(wb_data), 'h4444);

        flush = 1'b1;
        step();
        clear();
        set_lane(0, 1'b1, 1'b0, 5, 0, 'h0A0A, 0);
        set_lane(1, 1'b1, 1'b0, 5, 0, 'h0F0F, 15);
        step();
        clear();
        step();
        chk("wrap_first_lane", int'(wb_lane), 1);
        chk("wrap_first_data", int'(wb_data), 'h0F0F);
        step();
        chk("wrap_second_data", int'(wb_data), 'h0A0A);

        set_lane(0, 1'b1, 1'b1, 2, 'h1234, 0, 1);
        set_lane(1, 1'b1, 1'b1, 3, 'h5678, 0, 2);
        repeat (8) step();
        clear();
        repeat (6) step();

        flush = 1'b1;
        step();
        clear();
        for (int c = 0; c <= DEPTH; c++) begin
            set_lane(0, 1'b1, 1'b0, 7, 0, 'h7000 + c, 6);
            set_lane(1, 1'b1, 1'b0, 7, 0, 'h1000 + c, c);
            step();
        end
        clear();
        repeat (8) step();

        set_lane(0, 1'b1, 1'b0, 2, 0, 'h2222, 8);
        set_lane(1, 1'b1, 1'b0, 3, 0, 'h3333, 9);
        repeat (2) step();
        set_lane(0, 1'b1, 1'b0, 4, 0, 'hDEAD, 10);
        flush = 1'b1;
        step();
        clear();
        chk("flush_wb_en", int'(wb_en), 0);
        chk("flush_ready", int'(req_ready), 3);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("flush_no_write", int'(wb_en), 0);
        end

        set_lane(0, 1'b1, 1'b1, 6, 'h6666, 0, 11);
        set_lane(1, 1'b1, 1'b1, 3, 'h7777, 0, 12);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("midrst_wb_en", int'(wb_en), 0);
        chk("midrst_wb_rd", int'(wb_rd), 0);
        chk("midrst_wb_data", int'(wb_data), 0);
        exp_q.delete();
        for (int l = 0; l < NL; l++) mq[l].delete();
        m_rr = 0;
        m_rd = 0;
        m_data = 0;
        clear();
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_ready", int'(req_ready), 3);

        repeat (400) begin
            for (int i = 0; i < NL; i++)
                set_lane(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                         int'($urandom), int'($urandom), int'($urandom_range(0, 15)));
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        clear();
        repeat (10) step();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
